// File: rtl/ssd_scan_n_if.sv
// ssd_scan_n_if: load/mask/control inputs and scan outputs of the seven-segment scanner.
// Brightness exists only when SSD_BRIGHTNESS_EN is defined.
interface ssd_scan_n_if #(parameter int NUM_DIGITS = 4) ();
    logic                    Load;
    logic [4*NUM_DIGITS-1:0] Value;
    logic [NUM_DIGITS-1:0]   DpMask;
    logic [NUM_DIGITS-1:0]   BlankMask;
    logic                    LzSuppress;
    logic                    Active;
`ifdef SSD_BRIGHTNESS_EN
    logic [3:0]              Brightness;
`endif
    logic                    Pending;
    logic                    Frame;
    logic [NUM_DIGITS-1:0]   Enables;
    logic [7:0]              Cathodes;

    modport master (
        output Load, Value, DpMask, BlankMask, LzSuppress, Active,
`ifdef SSD_BRIGHTNESS_EN
        output Brightness,
`endif
        input  Pending, Frame, Enables, Cathodes
    );

    modport slave (
        input  Load, Value, DpMask, BlankMask, LzSuppress, Active,
`ifdef SSD_BRIGHTNESS_EN
        input  Brightness,
`endif
        output Pending, Frame, Enables, Cathodes
    );
endinterface

// File: rtl/ssd_scan_n.sv
// ssd_scan_n: N-digit seven-segment scanner with frame-aligned double-buffered load.
// SSD_BRIGHTNESS_EN adds a per-slot duty control on the enables.
module ssd_scan_n #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 50000,
    parameter int ACTIVE_LOW     = 1
) (
    input logic         Clk,
    input logic         Reset,
    ssd_scan_n_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_DIGIT);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] EN_OFF = ACTIVE_LOW != 0 ? '1 : '0;
    localparam logic [7:0] CAT_OFF = ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
    // segments {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SEG [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pend_q, pend_d;
    logic [VW-1:0]         sv_q, sv_d, dv_q, dv_d;
    logic [NUM_DIGITS-1:0] sd_q, sd_d, sb_q, sb_d, dd_q, dd_d, db_q, db_d;
    logic [NUM_DIGITS-1:0] en_q, en_d, onehot;
    logic [7:0]            cat_q, cat_d, seg;
    logic [NUM_DIGITS:0]   zhi;
    logic [3:0]            nib;
    logic                  term, last, frame, dark, lit;

    always_comb begin
        term   = cnt_q == CW'(CLKS_PER_DIGIT - 1);
        last   = idx_q == IW'(NUM_DIGITS - 1);
        frame  = term && last;
        cnt_d  = term ? '0 : cnt_q + 1'b1;
        idx_d  = term ? (last ? '0 : idx_q + 1'b1) : idx_q;
        sv_d   = bus.Load ? bus.Value : sv_q;
        sd_d   = bus.Load ? bus.DpMask : sd_q;
        sb_d   = bus.Load ? bus.BlankMask : sb_q;
        pend_d = bus.Load ? !frame : pend_q && !frame;
        // a Load landing on the frame cycle bypasses the shadow
        {dv_d, dd_d, db_d} = (frame && bus.Load) ? {bus.Value, bus.DpMask, bus.BlankMask} :
                             (frame && pend_q)   ? {sv_q, sd_q, sb_q} : {dv_q, dd_q, db_q};
        zhi[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) zhi[i] = zhi[i+1] && dv_q[4*i +: 4] == 4'h0;
        nib    = dv_q[4*int'(idx_q) +: 4];
        dark   = db_q[idx_q] || (bus.LzSuppress && idx_q != '0 && zhi[idx_q]);
        seg    = dark ? 8'h00 : {SEG[nib], dd_q[idx_q]};
        cat_d  = ACTIVE_LOW != 0 ? ~seg : seg;
`ifdef SSD_BRIGHTNESS_EN
        lit    = bus.Active && int'(cnt_q) < (int'(bus.Brightness) + 1) * CLKS_PER_DIGIT / 16;
`else
        lit    = bus.Active;
`endif
        onehot = NUM_DIGITS'(1) << idx_q;
        en_d   = lit ? (ACTIVE_LOW != 0 ? ~onehot : onehot) : EN_OFF;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            pend_q <= 1'b0;
            {sv_q, sd_q, sb_q, dv_q, dd_q, db_q} <= '0;
            en_q   <= EN_OFF;
            cat_q  <= CAT_OFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            {sv_q, sd_q, sb_q, dv_q, dd_q, db_q} <= {sv_d, sd_d, sb_d, dv_d, dd_d, db_d};
            en_q   <= en_d;
            cat_q  <= cat_d;
        end
    end

    assign bus.Pending  = pend_q;
    assign bus.Frame    = frame;
    assign bus.Enables  = en_q;
    assign bus.Cathodes = cat_q;
endmodule

// File: tb/tb_ssd_scan_n.sv
// tb_ssd_scan_n: directed checks of ssd_scan_n with NUM_DIGITS=4, CLKS_PER_DIGIT=4, ACTIVE_LOW=1.
module tb_ssd_scan_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ssd_scan_n_if #(.NUM_DIGITS(4)) bus ();
    ssd_scan_n #(.NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .ACTIVE_LOW(1)) dut (
        .Clk(clk), .Reset(rst), .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            step();
            ok = bus.Frame === 1'b1;
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        bus.Value = v;
        bus.DpMask = dp;
        bus.BlankMask = bl;
        bus.Load = 1'b1;
        step();
        bus.Load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (bus.Enables !== 4'hF) begin errors++; $display("FAIL reset_en got=%h exp=f", bus.Enables); end
        checks++; if (bus.Cathodes !== 8'hFF) begin errors++; $display("FAIL reset_cat got=%h exp=ff", bus.Cathodes); end
        checks++; if (bus.Pending !== 1'b0) begin errors++; $display("FAIL reset_pend got=%b exp=0", bus.Pending); end
        checks++; if (bus.Frame !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", bus.Frame); end
        rst = 1'b0;
        step();
        checks++; if (bus.Enables !== 4'b1110) begin errors++; $display("FAIL release_en got=%b exp=1110", bus.Enables); end
    endtask

    task automatic test_scan();
        bit ok;
        logic [7:0] exp [4] = '{8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111};
        load(16'h1234, 4'h0, 4'h0);
        checks++; if (bus.Pending !== 1'b1) begin errors++; $display("FAIL scan_pend_set got=%b exp=1", bus.Pending); end
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL scan_frame_timeout got=0 exp=1"); end
        step();
        checks++; if (bus.Pending !== 1'b0) begin errors++; $display("FAIL scan_pend_clr got=%b exp=0", bus.Pending); end
        for (int k = 0; k < 16; k++) begin
            step();
            checks++; if (bus.Enables !== ~(4'b0001 << (k / 4))) begin errors++; $display("FAIL scan_en k=%0d got=%b exp=%b", k, bus.Enables, ~(4'b0001 << (k / 4))); end
            checks++; if (bus.Cathodes !== exp[k/4]) begin errors++; $display("FAIL scan_cat k=%0d got=%b exp=%b", k, bus.Cathodes, exp[k/4]); end
            checks++; if (bus.Frame !== (k == 14)) begin errors++; $display("FAIL scan_frame k=%0d got=%b exp=%b", k, bus.Frame, k == 14); end
        end
    endtask

    task automatic test_masks();
        bit ok;
        logic [7:0] exp [4] = '{8'b10011000, 8'b00001101, 8'hFF, 8'b10011111};
        load(16'h1234, 4'b0001, 4'b0100);
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mask_frame_timeout got=0 exp=1"); end
        step();
        for (int k = 0; k < 16; k++) begin
            step();
            if (k % 4 == 0) begin
                checks++; if (bus.Cathodes !== exp[k/4]) begin errors++; $display("FAIL mask_cat d=%0d got=%b exp=%b", k / 4, bus.Cathodes, exp[k/4]); end
            end
        end
    endtask

    task automatic test_midframe_load();
        bit ok;
        repeat (5) step();
        load(16'hABCD, 4'h0, 4'h0);
        checks++; if (bus.Pending !== 1'b1) begin errors++; $display("FAIL mid_pend got=%b exp=1", bus.Pending); end
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_frame_timeout got=0 exp=1"); end
        checks++; if (bus.Cathodes !== 8'b10011111) begin errors++; $display("FAIL mid_old_cat got=%b exp=10011111", bus.Cathodes); end
        checks++; if (bus.Pending !== 1'b1) begin errors++; $display("FAIL mid_pend_hold got=%b exp=1", bus.Pending); end
        step();
        checks++; if (bus.Pending !== 1'b0) begin errors++; $display("FAIL mid_pend_clr got=%b exp=0", bus.Pending); end
        step();
        checks++; if (bus.Cathodes !== 8'b10000101) begin errors++; $display("FAIL mid_new_cat got=%b exp=10000101", bus.Cathodes); end
        checks++; if (bus.Enables !== 4'b1110) begin errors++; $display("FAIL mid_en got=%b exp=1110", bus.Enables); end
    endtask

    task automatic test_lz();
        bit ok;
        logic [7:0] exp [4] = '{8'b00000011, 8'b01001001, 8'hFF, 8'hFF};
        bus.LzSuppress = 1'b1;
        load(16'h0050, 4'h0, 4'h0);
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL lz_frame_timeout got=0 exp=1"); end
        step();
        for (int k = 0; k < 16; k++) begin
            step();
            if (k % 4 == 1) begin
                checks++; if (bus.Cathodes !== exp[k/4]) begin errors++; $display("FAIL lz_cat d=%0d got=%b exp=%b", k / 4, bus.Cathodes, exp[k/4]); end
            end
        end
        load(16'h0000, 4'h0, 4'h0);
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL lz0_frame_timeout got=0 exp=1"); end
        step();
        for (int k = 0; k < 16; k++) begin
            step();
            if (k % 4 == 1) begin
                checks++; if (bus.Cathodes !== (k < 4 ? 8'b00000011 : 8'hFF)) begin errors++; $display("FAIL lz0_cat d=%0d got=%b exp=%b", k / 4, bus.Cathodes, k < 4 ? 8'b00000011 : 8'hFF); end
            end
        end
        bus.LzSuppress = 1'b0;
    endtask

    task automatic test_bypass();
        bit ok;
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL byp_frame_timeout got=0 exp=1"); end
        load(16'h0007, 4'h0, 4'h0);
        checks++; if (bus.Pending !== 1'b0) begin errors++; $display("FAIL byp_pend got=%b exp=0", bus.Pending); end
        step();
        checks++; if (bus.Cathodes !== 8'b00011111) begin errors++; $display("FAIL byp_cat got=%b exp=00011111", bus.Cathodes); end
    endtask

    task automatic test_active_reset();
        bit ok;
        bus.Active = 1'b0;
        repeat (2) step();
        checks++; if (bus.Enables !== 4'hF) begin errors++; $display("FAIL inact_en got=%b exp=1111", bus.Enables); end
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL inact_frame got=0 exp=1"); end
        bus.Active = 1'b1;
        repeat (3) step();
        load(16'h1234, 4'h0, 4'h0);
        checks++; if (bus.Pending !== 1'b1) begin errors++; $display("FAIL rstp_pend_set got=%b exp=1", bus.Pending); end
        rst = 1'b1;
        step();
        checks++; if (bus.Pending !== 1'b0) begin errors++; $display("FAIL rstp_pend got=%b exp=0", bus.Pending); end
        checks++; if (bus.Enables !== 4'hF) begin errors++; $display("FAIL rstp_en got=%b exp=1111", bus.Enables); end
        checks++; if (bus.Cathodes !== 8'hFF) begin errors++; $display("FAIL rstp_cat got=%b exp=11111111", bus.Cathodes); end
        rst = 1'b0;
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstp_frame_timeout got=0 exp=1"); end
        repeat (2) step();
        checks++; if (bus.Cathodes !== 8'b00000011) begin errors++; $display("FAIL rstp_discard_cat got=%b exp=00000011", bus.Cathodes); end
    endtask

`ifdef SSD_BRIGHTNESS_EN
    task automatic test_brightness();
        bit ok;
        int lit_cnt;
        logic [3:0] b [2] = '{4'd3, 4'd15};
        int exp [2] = '{4, 16};
        for (int j = 0; j < 2; j++) begin
            bus.Brightness = b[j];
            wait_frame(ok);
            checks++; if (!ok) begin errors++; $display("FAIL bri_frame_timeout got=0 exp=1"); end
            step();
            lit_cnt = 0;
            for (int k = 0; k < 16; k++) begin
                step();
                if (bus.Enables !== 4'hF) lit_cnt++;
            end
            checks++; if (lit_cnt != exp[j]) begin errors++; $display("FAIL bri_duty b=%0d got=%0d exp=%0d", b[j], lit_cnt, exp[j]); end
        end
        bus.Brightness = 4'd15;
    endtask
`endif

    initial begin
        bus.Load = 1'b0;
        bus.Value = '0;
        bus.DpMask = '0;
        bus.BlankMask = '0;
        bus.LzSuppress = 1'b0;
        bus.Active = 1'b1;
`ifdef SSD_BRIGHTNESS_EN
        bus.Brightness = 4'd15;
`endif
        test_reset();
        test_scan();
        test_masks();
        test_midframe_load();
        test_lz();
        test_bypass();
        test_active_reset();
`ifdef SSD_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
